// File: rtl/gpio_lut_writer.sv
// GPIO-to-LUT write engine: decodes the PS GPIO bus, detects w_clk rising edges,
// pairs bytes into 16-bit words, and strobes writes into one lookup-table RAM.
// Optional `GPIO_WCLK_SYNC_EN adds a two-flop synchronizer on gpio_in[24].
module gpio_lut_writer #(
    parameter logic [15:0] ADDR_REG = 16'h0000,
    parameter logic [15:0] DATA_REG = 16'h0001,
    parameter int unsigned LUT_AW   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       gpio_in,
    output logic              lut_wr_en,
    output logic [LUT_AW-1:0] lut_wr_addr,
    output logic [15:0]       lut_wr_data,
    output logic [31:0]       status
);

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADDR,
        OP_DATA
    } op_e;

    logic [15:0]       bus_addr;
    logic [7:0]        bus_data;
    logic              w_clk_s;
    logic              w_clk_prev;
    logic              armed;
    logic              w_edge;
    op_e               op;

    logic              a_ph;
    logic              d_ph;
    logic [7:0]        a_hi;
    logic [7:0]        d_hi;
    logic [15:0]       addr_word;
    logic [LUT_AW-1:0] ptr;
    logic              wrap_flag;
    logic [15:0]       ptr_ext;
    logic              unused_gpio;

    assign bus_addr    = gpio_in[15:0];
    assign bus_data    = gpio_in[23:16];
    assign unused_gpio = ^gpio_in[31:25];

`ifdef GPIO_WCLK_SYNC_EN
    logic w_clk_meta;
    logic w_clk_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_clk_meta <= 1'b0;
            w_clk_sync <= 1'b0;
        end else begin
            w_clk_meta <= gpio_in[24];
            w_clk_sync <= w_clk_meta;
        end
    end

    assign w_clk_s = w_clk_sync;
`else
    // Same-clock GPIO block: use the raw strobe and save two cycles.
    assign w_clk_s = gpio_in[24];
`endif

    // A strobe already high when reset releases must fall before it can count.
    assign w_edge = w_clk_s & ~w_clk_prev & armed;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path infers a latch.
        op = OP_NONE;
        if (w_edge) begin
            if (bus_addr == ADDR_REG) begin
                op = OP_ADDR;
            end else if (bus_addr == DATA_REG) begin
                op = OP_DATA;
            end
        end
    end

    assign addr_word = {a_hi, bus_data};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_clk_prev  <= 1'b0;
            armed       <= 1'b0;
            a_ph        <= 1'b0;
            d_ph        <= 1'b0;
            a_hi        <= '0;
            d_hi        <= '0;
            ptr         <= '0;
            wrap_flag   <= 1'b0;
            lut_wr_en   <= 1'b0;
            lut_wr_addr <= '0;
            lut_wr_data <= '0;
        end else begin
            lut_wr_en  <= 1'b0;
            w_clk_prev <= w_clk_s;
            if (!w_clk_s) begin
                armed <= 1'b1;
            end

            case (op)
                OP_ADDR: begin
                    if (!a_ph) begin
                        a_hi <= bus_data;
                        a_ph <= 1'b1;
                    end else begin
                        ptr       <= addr_word[LUT_AW-1:0];
                        a_ph      <= 1'b0;
                        d_ph      <= 1'b0;
                        wrap_flag <= 1'b0;
                    end
                end
                OP_DATA: begin
                    if (!d_ph) begin
                        d_hi <= bus_data;
                        d_ph <= 1'b1;
                    end else begin
                        lut_wr_en   <= 1'b1;
                        lut_wr_addr <= ptr;
                        lut_wr_data <= {d_hi, bus_data};
                        ptr         <= ptr + LUT_AW'(1);
                        d_ph        <= 1'b0;
                        if (ptr == '1) begin
                            wrap_flag <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ptr_ext             = '0;
        ptr_ext[LUT_AW-1:0] = ptr;
    end

    assign status = {wrap_flag, 15'b0, ptr_ext};

endmodule

// File: tb/tb_gpio_lut_writer.sv
// Directed bench for gpio_lut_writer (LUT_AW=8): stimulus pushes expected strobes
// into a queue, a negedge monitor pops and compares each lut_wr_en pulse.
module tb_gpio_lut_writer;

    localparam logic [15:0] ADDR_REG = 16'h0000;
    localparam logic [15:0] DATA_REG = 16'h0001;
    localparam logic [15:0] FOREIGN  = 16'h0040;
`ifdef GPIO_WCLK_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] gpio = '0;
    logic        lut_wr_en;
    logic [7:0]  lut_wr_addr;
    logic [15:0] lut_wr_data;
    logic [31:0] status;

    exp_t exp_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   strobes = 0;
    int   pushed  = 0;

    gpio_lut_writer #(
        .ADDR_REG(ADDR_REG),
        .DATA_REG(DATA_REG),
        .LUT_AW  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gpio_in    (gpio),
        .lut_wr_en  (lut_wr_en),
        .lut_wr_addr(lut_wr_addr),
        .lut_wr_data(lut_wr_data),
        .status     (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // One byte on the bus: setup, w_clk high 3 cycles, low 2 cycles.
    task automatic gpio_byte(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        gpio = {7'h0, 1'b0, d, a};
        repeat (2) @(negedge clk);
        gpio[24] = 1'b1;
        repeat (3) @(negedge clk);
        gpio[24] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_strobe(input logic [7:0] a, input logic [15:0] d);
        exp_q.push_back('{addr: a, data: d});
        pushed++;
    endtask

    always @(negedge clk) begin
        if (rst && lut_wr_en) begin
            strobes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got addr 0x%02h data 0x%04h, none expected",
                         lut_wr_addr, lut_wr_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_addr", 32'(lut_wr_addr), 32'(e.addr));
                check("strobe_data", 32'(lut_wr_data), 32'(e.data));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_n;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_wr_en", 32'(lut_wr_en), 32'd0);
        check("reset_wr_addr", 32'(lut_wr_addr), 32'd0);
        check("reset_wr_data", 32'(lut_wr_data), 32'd0);
        check("reset_status", status, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Pointer load and single write
        gpio_byte(ADDR_REG, 8'h00);
        gpio_byte(ADDR_REG, 8'h05);
        gpio_byte(DATA_REG, 8'h12);
        expect_strobe(8'h05, 16'h1234);
        gpio_byte(DATA_REG, 8'h34);
        check("single_status", status, 32'd6);
        repeat (4) @(negedge clk);
        check("hold_addr", 32'(lut_wr_addr), 32'h05);
        check("hold_data", 32'(lut_wr_data), 32'h1234);

        // Pending data hi byte discarded by an address write
        gpio_byte(DATA_REG, 8'hAA);
        gpio_byte(ADDR_REG, 8'h00);
        gpio_byte(ADDR_REG, 8'h03);
        gpio_byte(DATA_REG, 8'h01);
        expect_strobe(8'h03, 16'h0102);
        gpio_byte(DATA_REG, 8'h02);
        check("discard_status", status, 32'd4);

        // Foreign address between hi and lo bytes
        gpio_byte(DATA_REG, 8'h56);
        gpio_byte(FOREIGN, 8'h99);
        gpio_byte(FOREIGN, 8'h77);
        check("foreign_status", status, 32'd4);
        expect_strobe(8'h04, 16'h5678);
        gpio_byte(DATA_REG, 8'h78);
        check("foreign_after", status, 32'd5);

        // Pending address hi byte survives a data pair
        gpio_byte(ADDR_REG, 8'hAB);
        gpio_byte(DATA_REG, 8'h11);
        expect_strobe(8'h05, 16'h1122);
        gpio_byte(DATA_REG, 8'h22);
        gpio_byte(ADDR_REG, 8'h07);
        check("addr_pending_status", status, 32'd7);

        // Full fill with wrap
        gpio_byte(ADDR_REG, 8'h00);
        gpio_byte(ADDR_REG, 8'h00);
        for (int i = 0; i < 256; i++) begin
            gpio_byte(DATA_REG, 8'h00);
            expect_strobe(8'(i), {8'h00, 8'(i)});
            gpio_byte(DATA_REG, 8'(i));
        end
        check("wrap_status", status, 32'h8000_0000);
        gpio_byte(ADDR_REG, 8'h00);
        gpio_byte(ADDR_REG, 8'h10);
        check("wrap_cleared", status, 32'h0000_0010);

        // Reset after a data hi byte
        gpio_byte(DATA_REG, 8'hEE);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_status", status, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        gpio_byte(DATA_REG, 8'h9A);
        expect_strobe(8'h00, 16'h9ABC);
        gpio_byte(DATA_REG, 8'hBC);
        check("midreset_after", status, 32'd1);

        // w_clk held high across reset release
        @(negedge clk);
        gpio = {7'h0, 1'b1, 8'h55, DATA_REG};
        rst  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("highrel_status", status, 32'd0);
        gpio[24] = 1'b0;
        repeat (3) @(negedge clk);
        gpio_byte(DATA_REG, 8'h01);
        expect_strobe(8'h00, 16'h0102);
        gpio_byte(DATA_REG, 8'h02);
        check("highrel_after", status, 32'd1);

        // Latency from first sampling edge to strobe
        gpio_byte(DATA_REG, 8'h5A);
        @(negedge clk);
        gpio = {7'h0, 1'b0, 8'hA5, DATA_REG};
        repeat (2) @(negedge clk);
        expect_strobe(8'h01, 16'h5AA5);
        gpio[24] = 1'b1;
        lat_n = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            lat_n++;
            if (lut_wr_en) break;
        end
        check("latency_edges", 32'(lat_n), 32'(LAT));
        repeat (3) @(negedge clk);
        gpio[24] = 1'b0;
        repeat (3) @(negedge clk);
        check("latency_status", status, 32'd2);

        // Every expected strobe seen, nothing extra
        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("strobe_count", 32'(strobes), 32'(pushed));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
